// File: rtl/b3_pkg.sv
// Shared base-3 digit definitions: digit type, digit constants and per-digit helpers.
package b3_pkg;

  typedef logic [1:0] b3_digit_t;

  localparam b3_digit_t B3_ZERO = 2'b00;
  localparam b3_digit_t B3_ONE  = 2'b01;
  localparam b3_digit_t B3_TWO  = 2'b10;

  // Code 11 is not a legal digit; fold it onto the largest legal value.
  function automatic b3_digit_t b3_clamp(input b3_digit_t x);
    return (x == 2'b11) ? B3_TWO : x;
  endfunction

  function automatic b3_digit_t b3_dec(input b3_digit_t x);
    b3_digit_t r;
    case (x)
      B3_TWO:  r = B3_ONE;
      B3_ONE:  r = B3_ZERO;
      default: r = B3_TWO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/b3_down_digit.sv
// One base-3 down-counting digit with parallel load; bo passes the borrow on when at 00.
module b3_down_digit
  import b3_pkg::*;
(
  input  logic      clock,
  input  logic      reset_,
  input  logic      ld,
  input  b3_digit_t d,
  input  logic      bi,
  output b3_digit_t q,
  output logic      bo
);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_)  q <= B3_ZERO;
    else if (ld)  q <= b3_clamp(d);
    else if (bi)  q <= b3_dec(q);
  end

  assign bo = bi & (q == B3_ZERO);

endmodule

// File: rtl/b3_down_counter.sv
// N_DIGITS-digit base-3 down counter with load, borrow-in ei and borrow-out eu.
// Optional B3_DOWN_COUNTER_SATURATE_EN: decrement at zero holds instead of wrapping.
module b3_down_counter
  import b3_pkg::*;
#(
  parameter int N_DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  ei,
  input  logic                  ld,
  input  logic [2*N_DIGITS-1:0] d,
  output logic [2*N_DIGITS-1:0] q,
  output logic                  eu,
  output logic                  zero
);

  logic [N_DIGITS:0] borrow;

  assign zero = (q == '0);

`ifdef B3_DOWN_COUNTER_SATURATE_EN
  assign borrow[0] = ei & ~zero;
`else
  assign borrow[0] = ei;
`endif

  genvar g;
  generate
    for (g = 0; g < N_DIGITS; g++) begin : g_digit
      b3_down_digit u_digit (
        .clock  (clock),
        .reset_ (reset_),
        .ld     (ld),
        .d      (d[2*g +: 2]),
        .bi     (borrow[g]),
        .q      (q[2*g +: 2]),
        .bo     (borrow[g+1])
      );
    end
  endgenerate

  // A gated (saturating) chain never borrows out at zero, so ei&zero keeps eu alive for upper stages.
  assign eu = (borrow[N_DIGITS] | (ei & zero)) & ~ld;

endmodule

// File: tb/tb_b3_down_counter.sv
// Randomized self-checking bench for b3_down_counter (N_DIGITS = 2) against an integer count model.
module tb_b3_down_counter;

  localparam int N   = 2;
  localparam int MOD = 9;

  logic           clock = 1'b0;
  logic           reset_;
  logic           ei, ld;
  logic [2*N-1:0] d;
  logic [2*N-1:0] q;
  logic           eu, zero;

  int checks = 0;
  int errors = 0;
  int m      = 0;

  b3_down_counter #(.N_DIGITS(N)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .ei     (ei),
    .ld     (ld),
    .d      (d),
    .q      (q),
    .eu     (eu),
    .zero   (zero)
  );

  always #5 clock = ~clock;

  function automatic int load_val(input logic [2*N-1:0] x);
    int v = 0;
    int w = 1;
    for (int k = 0; k < N; k++) begin
      int dig = int'(x[2*k +: 2]);
      if (dig > 2) dig = 2;
      v = v + dig * w;
      w = w * 3;
    end
    return v;
  endfunction

  function automatic logic [2*N-1:0] enc(input int v);
    logic [2*N-1:0] r = '0;
    int t = v;
    for (int k = 0; k < N; k++) begin
      r[2*k +: 2] = 2'(t % 3);
      t = t / 3;
    end
    return r;
  endfunction

  function automatic int next_val(input int cur);
`ifdef B3_DOWN_COUNTER_SATURATE_EN
    return (cur == 0) ? 0 : cur - 1;
`else
    return (cur == 0) ? MOD - 1 : cur - 1;
`endif
  endfunction

  // Reference: the count as a plain integer in [0, 3^N).
  always @(posedge clock or negedge reset_) begin
    if (!reset_)   m <= 0;
    else if (ld)   m <= load_val(d);
    else if (ei)   m <= next_val(m);
  end

  always @(negedge clock) begin
    checks++;
    if (q !== enc(m) || zero !== (m == 0) || eu !== (ei && m == 0 && !ld)) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t q=%b zero=%b eu=%b expected q=%b zero=%b eu=%b",
               $time, q, zero, eu, enc(m), (m == 0), (ei && m == 0 && !ld));
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] seq [0:10];

  initial begin
    seq = '{4'b0000, 4'b1010, 4'b1001, 4'b1000, 4'b0110, 4'b0101,
            4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1010};
    reset_ = 1'b0; ei = 1'b1; ld = 1'b0; d = '0;
    repeat (2) tick();
    chk("reset_q", 8'(q), 8'h00);
    chk("reset_zero", 8'(zero), 8'h01);
    chk("reset_eu", 8'(eu), 8'h01);
    reset_ = 1'b1;

    // Free-running decrement through a full wrap.
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("run_q_%0d", i), 8'(q), 8'(seq[i]));
      chk($sformatf("run_eu_%0d", i), 8'(eu), 8'((i == 0 || i == 9) ? 1 : 0));
      if (i < 10) tick();
    end

    // Load 5 and count to zero.
    ld = 1'b1; ei = 1'b0; d = 4'b0110; tick();
    chk("load5_q", 8'(q), 8'b0110);
    ld = 1'b0; ei = 1'b1;
    repeat (5) tick();
    chk("cnt5_q", 8'(q), 8'h00);
    chk("cnt5_zero", 8'(zero), 8'h01);
    chk("cnt5_eu", 8'(eu), 8'h01);

    // Load and borrow together at zero: load wins, eu suppressed.
    ld = 1'b1; ei = 1'b1; d = 4'b1000; #1;
    chk("ldei_eu", 8'(eu), 8'h00);
    tick();
    chk("ldei_q", 8'(q), 8'b1000);

    // Clamped load, then gapped borrows.
    ld = 1'b1; ei = 1'b0; d = 4'b1111; tick();
    chk("clamp_q", 8'(q), 8'b1010);
    ld = 1'b0; ei = 1'b1; tick();
    chk("gap_dec1", 8'(q), 8'b1001);
    ei = 1'b0; repeat (2) tick();
    chk("gap_hold", 8'(q), 8'b1001);
    ei = 1'b1; tick();
    chk("gap_dec2", 8'(q), 8'b1000);

    // Asynchronous reset between edges.
    ld = 1'b1; ei = 1'b0; d = 4'b0101; tick();
    chk("pre_rst_q", 8'(q), 8'b0101);
    ld = 1'b0;
    #2 reset_ = 1'b0;
    #1 chk("async_rst_q", 8'(q), 8'h00);
    reset_ = 1'b1;

`ifdef B3_DOWN_COUNTER_SATURATE_EN
    ei = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_q_%0d", i), 8'(q), 8'h00);
      chk($sformatf("sat_eu_%0d", i), 8'(eu), 8'h01);
    end
`endif

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock);
      #1;
      ld = ($urandom_range(0, 5) == 0);
      ei = ($urandom_range(0, 2) != 0);
      d  = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 reset_ = 1'b0;
        #1 reset_ = 1'b1;
      end
    end

    @(posedge clock);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/b3_down_counter.md
# b3_down_counter

Synchronous base-3 down counter of N_DIGITS ternary digits, each digit encoded on 2 bits (00, 01, 10), with parallel load and a borrow chain. It is the decrementing counterpart of the base-3 up counter: `ei` is borrow-in (decrement enable) and `eu` is borrow-out, so instances cascade least-significant first. It is used for countdown timers and for pairing with up counters in occupancy tracking.

## Interface
- N_DIGITS, default 2: number of base-3 digits, at least 1; the modulus is 3^N_DIGITS.
- clock  in  1  system clock; all state updates on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- ei  in  1  borrow-in / decrement enable.
- ld  in  1  synchronous parallel load; has priority over `ei`.
- d  in  2*N_DIGITS  load value; digit k is at bits [2k+1:2k].
- q  out  2*N_DIGITS  current count, same digit layout as `d`.
- eu  out  1  borrow-out, combinational.
- zero  out  1  high when every digit is 00, combinational from `q`.

## Operation
- Digit encoding: 00 = 0, 01 = 1, 10 = 2. Code 11 is invalid and never held in state.
- Reset (`reset_` low): all digits are 00, so `q` = 0 and `zero` = 1. `eu` = `ei`, because the count is zero and `ld` is assumed low during reset.
- Per clock edge, highest priority first:
  1. `ld` = 1: `q` <= `d`. Any input digit of 11 is stored as 10 (clamped, per digit).
  2. `ld` = 0 and `ei` = 1: the count decrements by 1 in base 3.
  3. Otherwise the count holds.
- Decrement rule: digit 0 always receives the borrow `ei`. Digit k receives a borrow when `ei` = 1 and all lower digits are 00. A digit receiving a borrow goes 10->01, 01->00, 00->10.
- Wrap-around: decrementing from all-00 gives all-10, which is 3^N_DIGITS - 1 (8 for N_DIGITS = 2).
- `eu` = `ei` AND `zero` AND NOT `ld`. It signals that the next edge wraps, or that this instance's borrow should be passed up the chain.
- Simultaneous `ld` and `ei`: the load wins, `ei` is ignored, and `eu` = 0.
- Reset asserted mid-count clears `q` immediately, independent of `clock`.

## Timing
- `q` has 1-cycle latency from `ld` or `ei` sampled at a rising edge.
- `eu` and `zero` are combinational, with no register stage. `eu` is valid in the same cycle as `ei`.
- Cascading: connect the lower instance's `eu` to the upper instance's `ei`. There is no added latency; the chain is combinational across instances.
- After `reset_` deasserts, the first count update happens on the first rising edge that samples `ei` or `ld` high.

## Configuration
- B3_DOWN_COUNTER_SATURATE_EN:
  - Defined: a decrement at zero holds all digits at 00 instead of wrapping. `eu` still asserts under the same equation, so cascaded upper stages still see the borrow.
  - Undefined: wrap-around as described above.
  - Load behaviour is identical in both modes.

## Structure
- Shared package b3_pkg holds:
  - digit constants B3_ZERO (2'b00), B3_ONE (2'b01), B3_TWO (2'b10);
  - a digit typedef (2 bits);
  - the clamp function that maps 11 to 10.
- Sub-module b3_down_digit implements one digit: inputs `clock`, `reset_`, `ld`, `d`, `bi`; outputs `q` and `bo`, where `bo` = `bi` AND (`q` == 00).
  - The top level instantiates N_DIGITS of these via a generate loop, chaining `bo` to the next digit's `bi`.
  - It derives `zero` and `eu` from the chain.
  - Saturation is handled at the top level by gating digit 0's `bi` when `zero` is high.

## Test plan
All cases use N_DIGITS = 2.
- Reset then `ei` = 1 for 10 cycles: `q` runs 00_00 -> 10_10 -> 10_01 -> 10_00 -> 01_10 ... -> 00_00 -> 10_10. `eu` = 1 exactly in the cycles where `q` = 00_00.
- `ld` = 1 with `d` = 01_10 (value 5), then `ei` = 1 for 5 cycles: `q` reaches 00_00 and `zero` = 1. On the 6th cycle `eu` = 1.
- `ld` = 1 and `ei` = 1 together, with `d` = 10_00 and `q` = 00_00: `eu` = 0 in that cycle, and next `q` = 10_00.
- `ld` with `d` = 11_11: `q` = 10_10 (clamped). `ei` pulses with gaps of `ei` = 0: the count holds during the gaps.
- `reset_` pulsed low between edges while `q` = 01_01: `q` = 00_00 immediately, before the next edge.
- With B3_DOWN_COUNTER_SATURATE_EN defined and `q` = 00_00, `ei` = 1 for 3 cycles: `q` stays 00_00 and `eu` = 1 each cycle.
